// File: rtl/alu_exec_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_pkg
// Shared types for the execute-stage ALU:
//   alu_operation_type : decoded operation coming from ALU control
//   alu_state_type     : execute-stage sequencing (IDLE / SHIFT / DONE)
// Helpers:
//   is_shift_op        : true for SLL/SRL/SRA
//   is_known_op        : true for every encoded operation
// ---------------------------------------------------------------------------
package alu_exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10
  } alu_operation_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_type;

  function automatic logic is_shift_op(alu_operation_type op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic is_known_op(alu_operation_type op);
    return op inside {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
                      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI};
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// ---------------------------------------------------------------------------
// alu_exec_if
// Issue/result handshake bundle of the execute-stage ALU.
//   in_valid/in_ready   : operation transfer (issue -> ALU)
//   op, a, b            : decoded operation and XLEN operands
//   out_valid/out_ready : result transfer (ALU -> writeback/branch)
//   result, zero        : computed value and its ==0 flag
//   busy                : iterative shift in progress
// master = issue/writeback side, slave = the ALU.
// ---------------------------------------------------------------------------
interface alu_exec_if #(parameter int XLEN = 32);
  import alu_exec_pkg::*;

  logic              in_valid;
  logic              in_ready;
  alu_operation_type op;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   result;
  logic              zero;
  logic              busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );

endinterface

// File: rtl/alu_exec_shifter.sv
// ---------------------------------------------------------------------------
// alu_shifter
// Iterative one-bit-per-cycle shift engine.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : capture value_in / shamt_in / direction
//   left, arith         : SLL when left, else SRA when arith, else SRL
//   value_in, shamt_in  : operand and shift amount
//   value_out           : working value shifted one more position
//   done                : the shift performed at the coming edge is the last
// ---------------------------------------------------------------------------
module alu_shifter #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            left,
  input  logic            arith,
  input  logic [XLEN-1:0] value_in,
  input  logic [SHW-1:0]  shamt_in,
  output logic [XLEN-1:0] value_out,
  output logic            done
);

  logic [XLEN-1:0] work_q;
  logic [SHW-1:0]  cnt_q;
  logic            left_q;
  logic            arith_q;
  logic [XLEN-1:0] shifted;

  always_comb begin
    if (left_q) shifted = {work_q[XLEN-2:0], 1'b0};
    else        shifted = {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};
  end

  // datapath: working value and direction, no reset needed
  always_ff @(posedge clk) begin
    if (load) begin
      work_q  <= value_in;
      left_q  <= left;
      arith_q <= arith;
    end else if (cnt_q != '0) begin
      work_q  <= shifted;
    end
  end

  // control: remaining shift count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (load)           cnt_q <= shamt_in;
    else if (cnt_q != '0)    cnt_q <= cnt_q - SHW'(1);
  end

  assign value_out = shifted;
  assign done      = (cnt_q == SHW'(1));

endmodule

// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec
// Execute-stage ALU. Logic/arithmetic/compare ops complete one cycle after
// acceptance; shifts run on an iterative engine (shamt+1 cycles) unless
// ALU_BARREL_SHIFT_EN is defined, in which case shifts are single-cycle too
// and busy is tied low.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   io    : alu_exec_if.slave (in_valid/in_ready, op, a, b,
//           out_valid/out_ready, result, zero, busy)
// Configuration macro: ALU_BARREL_SHIFT_EN
// ---------------------------------------------------------------------------
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  io
);

  localparam int SHW = $clog2(XLEN);

  alu_state_type   state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q;
  logic            res_en;
  logic            in_ready_c;
  logic            accept;

  // Single-cycle result for an accepted op. Without the barrel shifter a
  // shift only reaches here with shamt==0, so it passes a through.
  function automatic logic [XLEN-1:0] compute(alu_operation_type o,
                                               logic [XLEN-1:0] x,
                                               logic [XLEN-1:0] y);
    logic signed [XLEN-1:0] xs;
    logic signed [XLEN-1:0] ys;
    xs = x;
    ys = y;
    case (o)
      ALU_ADD:  return x + y;
      ALU_SUB:  return x - y;
      ALU_XOR:  return x ^ y;
      ALU_OR:   return x | y;
      ALU_AND:  return x & y;
      ALU_SLT:  return {{(XLEN-1){1'b0}}, (xs < ys)};
      ALU_SLTU: return {{(XLEN-1){1'b0}}, (x < y)};
      ALU_LUI:  return y;
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL:  return x << y[SHW-1:0];
      ALU_SRL:  return x >> y[SHW-1:0];
      ALU_SRA:  return xs >>> y[SHW-1:0];
`else
      ALU_SLL, ALU_SRL, ALU_SRA: return x;
`endif
      default:  return '0;
    endcase
  endfunction

`ifndef ALU_BARREL_SHIFT_EN
  logic [SHW-1:0]  shamt;
  logic            load_sh;
  logic [XLEN-1:0] sh_value;
  logic            sh_done;

  assign shamt = io.b[SHW-1:0];

  alu_shifter #(.XLEN(XLEN)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_sh),
    .left      (io.op == ALU_SLL),
    .arith     (io.op == ALU_SRA),
    .value_in  (io.a),
    .shamt_in  (shamt),
    .value_out (sh_value),
    .done      (sh_done)
  );
`endif

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    res_en     = 1'b0;
    result_d   = result_q;
`ifndef ALU_BARREL_SHIFT_EN
    load_sh    = 1'b0;
`endif
    case (state_q)
      IDLE:  in_ready_c = 1'b1;
      SHIFT: begin
`ifndef ALU_BARREL_SHIFT_EN
        if (sh_done) begin
          state_d  = DONE;
          res_en   = 1'b1;
          result_d = sh_value;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        in_ready_c = io.out_ready;
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    accept = io.in_valid && in_ready_c;
    if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
      if (is_shift_op(io.op) && (shamt != '0)) begin
        state_d = SHIFT;
        load_sh = 1'b1;
      end else
`endif
      begin
        state_d  = DONE;
        res_en   = 1'b1;
        result_d = compute(io.op, io.a, io.b);
      end
    end
  end

  // result register stage: zero flag registered together with result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      if (res_en) begin
        result_q <= result_d;
        zero_q   <= (result_d == '0);
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && accept && !is_known_op(io.op))
      $error("alu_exec: unknown op %0d", io.op);
  end
`endif

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = (state_q == DONE);
  assign io.result    = result_q;
  assign io.zero      = zero_q;
`ifdef ALU_BARREL_SHIFT_EN
  assign io.busy      = 1'b0;
`else
  assign io.busy      = (state_q == SHIFT);
`endif

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execute-stage ALU sitting directly downstream of the ALU control decoder.
- Consumes the decoded alu_operation_type op plus two XLEN operands from the issue side, computes the result and presents it to writeback/branch logic.
- Logic/arithmetic/compare ops complete in one cycle.
- Shifts run on an iterative one-bit-per-cycle engine.
- Valid/ready handshakes on both input and output sides.

Parameters:
- XLEN, 32, operand/result width.
- SHW, $clog2(XLEN), shift-amount width (derived, not overridable).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept a new operation.
- op  input  alu_operation_type  operation from ALU control.
- a  input  XLEN  operand A (rs1 / PC).
- b  input  XLEN  operand B (rs2 / immediate; for LUI the already-shifted immediate).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  computed value.
- zero  output  1  result == 0, for branch evaluation.
- busy  output  1  shift in progress.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - in_ready=1, out_valid=0, result=0, zero=1, busy=0.
  - Reset mid-shift abandons the operation; no output is produced.
- Handshakes:
  - Input transfer when in_valid&&in_ready.
  - Output transfer when out_valid&&out_ready.
  - result/zero are held stable while out_valid&&!out_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready), so back-to-back single-cycle ops sustain one op per cycle.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On accept of a non-shift op: compute, register result, go to DONE. Latency is 1 cycle from accept to out_valid.
  - On accept of SLL/SRL/SRA:
    - Latch a, shamt=b[SHW-1:0], op.
    - If shamt==0: result=a, go to DONE.
    - Otherwise go to SHIFT.
- SHIFT:
  - Each cycle shift the working register by 1: SLL left, SRL logical right, SRA arithmetic right.
  - Decrement shamt; when shamt reaches 0, go to DONE.
  - Total latency = shamt+1 cycles.
  - in_ready=0 and busy=1 throughout.
- DONE:
  - out_valid=1.
  - On out_ready: if in_valid, accept the new op (same rules as IDLE); else go to IDLE.
- Arithmetic (XLEN wide, wrap-around, no overflow flag):
  - ADD: a+b.
  - SUB: a-b.
  - XOR, OR, AND: bitwise.
  - SLT: signed a<b, zero-extended to XLEN.
  - SLTU: unsigned compare.
  - LUI: b.
  - Upper bits of b beyond SHW are ignored for shifts.
- Unknown op value: result=0, completes in 1 cycle; simulation-only $error.
- zero is registered alongside result.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined:
  - Shifts are computed combinationally in IDLE/DONE accept with 1-cycle latency, like other ops.
  - SHIFT state unreachable; busy tied 0.
- Undefined: iterative shifter as above.

Decomposition:
- Shared package common:
  - Add alu_state_type enum {IDLE, SHIFT, DONE}.
  - alu_operation_type is already there; reuse it unchanged.
- Sub-module alu_shifter: iterative engine.
  - Inputs: load, dir/arith, value, shamt.
  - Outputs: value, done.
  - Instantiated only when ALU_BARREL_SHIFT_EN is undefined.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT (a=1, op=SLL, b=20, after 5 cycles) -> out_valid=0, in_ready=1, zero=1 immediately; no result emitted after release.
- Single-cycle ops, out_ready=1 held:
  - ADD 0xFFFFFFFF+1 -> result=0, zero=1, 1 cycle later.
  - SUB 5-7 -> 0xFFFFFFFE.
  - SLT 0xFFFFFFFF<1 -> 1.
  - SLTU same operands -> 0.
  - Issue these back-to-back -> one result per cycle.
- Shifts (macro undefined):
  - SRA a=0x80000000, b=31 -> 0xFFFFFFFF after 32 cycles, busy high for 31.
  - SLL b=0x20 (shamt 0) -> result=a after 1 cycle.
- Backpressure: out_ready=0 for 4 cycles after XOR 0xF0F0^0x0FF0 -> result=0xFF00 held stable, in_ready=0; releases on out_ready=1 with a pending LUI b=0x12345000 accepted the same cycle.
- ALU_BARREL_SHIFT_EN defined: SRL a=0x80000000, b=4 -> 0x08000000 in 1 cycle, busy never asserted.
- Random ops vs. reference model, random out_ready stalls: results and order match; no result is dropped or duplicated.
